life_scan_ctrl: RTL
===================

LIFE_SCAN_CTRL -- requirements
Module: life_scan_ctrl

Interface
REQ-001 The block SHALL have parameter N_CELLS, default 16, giving the number of cells in the array scan chain.
REQ-002 The block SHALL have port clk, input, 1 bit, the single system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit, synchronous active-high reset.
REQ-004 The block SHALL have port step, input, 1 bit, pacing enable; one scan shift is allowed per cycle with step=1 (tie high for full rate, or drive from a timer trigger).
REQ-005 The block SHALL have port start_read, input, 1 bit, request a non-destructive read of the board.
REQ-006 The block SHALL have port start_write, input, 1 bit, request a load of wr_pattern into the board; the old board is captured at the same time.
REQ-007 The block SHALL have port wr_pattern, input, N_CELLS bits, the pattern to load; bit N_CELLS-1 is the first cell out of the chain.
REQ-008 The block SHALL have port scan_read_val, input, 1 bit, the chain-tail cell from the array, valid in any cycle with scan=1.
REQ-009 The block SHALL have port scan, output, 1 bit, array shift strobe; the array shifts one position in each cycle where scan=1.
REQ-010 The block SHALL have port scan_write_val, output, 1 bit, the value inserted at the chain head.
REQ-011 The block SHALL have port scan_write_enb, output, 1 bit; when 1 the array inserts scan_write_val, otherwise it recirculates scan_read_val.
REQ-012 The block SHALL have port rd_pattern, output, N_CELLS bits, the last captured board, first-out cell in the MSB.
REQ-013 The block SHALL have port busy, output, 1 bit, high while an operation is in progress.
REQ-014 The block SHALL have port done, output, 1 bit, a single-cycle completion pulse.

Function
REQ-015 The FSM SHALL have three states: IDLE, SHIFT and FINISH.
REQ-016 In IDLE, a cycle with start_read or start_write high SHALL move the FSM to SHIFT, clear the shift counter, load wr_pattern into the write shadow register, and latch the mode (write if start_write=1).
REQ-017 If start_read and start_write are both high in the same cycle, write mode SHALL apply.
REQ-018 While busy=1, start_read and start_write SHALL be ignored and never queued; wr_pattern changes after the start cycle SHALL have no effect.
REQ-019 scan SHALL equal (state==SHIFT && step), combinationally, so no shift occurs in SHIFT cycles with step=0 and all state holds in those cycles.
REQ-020 scan_write_enb SHALL be 1 throughout SHIFT in write mode and 0 otherwise.
REQ-021 scan_write_val SHALL equal the write shadow MSB in write mode and 0 otherwise.
REQ-022 On each scan=1 cycle: the capture register SHALL shift left with scan_read_val entering the LSB, the write shadow SHALL shift left, and the counter SHALL increment.
REQ-023 The N_CELLS-th shift SHALL move the FSM to FINISH; the counter SHALL be wide enough to hold N_CELLS and SHALL never wrap mid-operation.
REQ-024 In FINISH, rd_pattern SHALL be loaded from the capture register, done SHALL be 1 for exactly that cycle, and the FSM SHALL return to IDLE.
REQ-025 With step held at 1, latency SHALL be: start in cycle 0; scan high in cycles 1..N_CELLS; done high in cycle N_CELLS+1; a new start is accepted in cycle N_CELLS+2.
REQ-026 busy SHALL be 1 in SHIFT and FINISH, and 0 in IDLE.
REQ-027 rd_pattern SHALL change only in FINISH or on reset.
REQ-028 A read operation SHALL leave the array contents unchanged after N_CELLS recirculating shifts.

Reset
REQ-029 Reset SHALL put the FSM in IDLE, clear the counter, shadow and capture registers, and set rd_pattern=0, busy=0, done=0, scan=0, scan_write_enb=0 and scan_write_val=0.
REQ-030 Reset SHALL take priority over any start and over step in the same cycle.
REQ-031 Reset during SHIFT SHALL abort the operation with no done pulse; the array is left partially rotated and this is accepted.

Verification
REQ-032 Read of a board holding 16'h33CC with step=1: scan is high for exactly 16 cycles -> done in cycle 17, rd_pattern=16'h33CC, and the board is still 16'h33CC.
REQ-033 Write of wr_pattern=16'h6186 over board 16'h0700: after done, rd_pattern=16'h0700, the board is 16'h6186, and scan_write_enb was high for all 16 shifts.
REQ-034 step pulsed once every 3 cycles during a read of 16'h3300: exactly 16 scan pulses occur, each coinciding with a step pulse, and the result is 16'h3300.
REQ-035 start_read and start_write together with wr_pattern=16'hFFFF: write mode is used and the board becomes 16'hFFFF; starts issued while busy produce no second operation.
REQ-036 Reset asserted at shift 7: the next cycle has busy=0, rd_pattern=0 and no done pulse; a following read completes normally.

Source files
------------

// File: rtl/life_scan_ctrl.sv
`default_nettype none
// ============================================================================
// life_scan_ctrl : scan-chain read/write controller for a cellular array board
// Revision 1.0 - initial release
// ============================================================================
module life_scan_ctrl #(
   parameter int N_CELLS = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               step,
   input  logic               start_read,
   input  logic               start_write,
   input  logic [N_CELLS-1:0] wr_pattern,
   input  logic               scan_read_val,
   output logic               scan,
   output logic               scan_write_val,
   output logic               scan_write_enb,
   output logic [N_CELLS-1:0] rd_pattern,
   output logic               busy,
   output logic               done
);

   // Counter must be able to represent N_CELLS itself so it never wraps mid-operation.
   localparam int                c_cnt_w      = $clog2(N_CELLS + 1);
   localparam logic [c_cnt_w-1:0] c_last_shift = c_cnt_w'(N_CELLS - 1);
   localparam logic [c_cnt_w-1:0] c_cnt_one    = c_cnt_w'(1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      FINISH = 2'd2
   } state_t;

   state_t               state_q,   state_d;
   logic [c_cnt_w-1:0]   cnt_q,     cnt_d;
   logic                 mode_q,    mode_d;
   logic [N_CELLS-1:0]   shadow_q,  shadow_d;
   logic [N_CELLS-1:0]   capture_q, capture_d;
   logic [N_CELLS-1:0]   rd_q,      rd_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         mode_q    <= 1'b0;
         shadow_q  <= '0;
         capture_q <= '0;
         rd_q      <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         mode_q    <= mode_d;
         shadow_q  <= shadow_d;
         capture_q <= capture_d;
         rd_q      <= rd_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      mode_d    = mode_q;
      shadow_d  = shadow_q;
      capture_d = capture_q;
      rd_d      = rd_q;
      case (state_q)
         IDLE: begin
            // Write wins when both requests arrive together.
            if (start_read || start_write) begin
               state_d  = SHIFT;
               cnt_d    = '0;
               shadow_d = wr_pattern;
               mode_d   = start_write;
            end
         end
         SHIFT: begin
            // Cycles without step leave every register untouched.
            if (step) begin
               capture_d = (capture_q << 1) | N_CELLS'(scan_read_val);
               shadow_d  = shadow_q << 1;
               cnt_d     = cnt_q + c_cnt_one;
               if (cnt_q == c_last_shift) begin
                  state_d = FINISH;
               end
            end
         end
         FINISH: begin
            rd_d    = capture_q;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign scan           = (state_q == SHIFT) && step;
   assign scan_write_enb = (state_q == SHIFT) && mode_q;
   assign scan_write_val = scan_write_enb && shadow_q[N_CELLS-1];
   assign rd_pattern     = rd_q;
   assign busy           = (state_q != IDLE);
   assign done           = (state_q == FINISH);

endmodule
`default_nettype wire
